// File: rtl/l2_lookup_sequencer.sv
// L2 front-end lookup: splits a request address, scans the indexed set one way per
// cycle, reports hit way or chosen fill victim to the update stage.
module l2_lookup_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int ASSOC    = 8,
    parameter int WAY_W    = 3,
    parameter int CNT_W    = 3,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               arr_rd_en,
    output logic [INDEX_W-1:0] arr_index,
    output logic [WAY_W-1:0]   arr_way,
    input  logic [TAG_W-1:0]   arr_rd_tag,
    input  logic [1:0]         arr_rd_mesi,
    input  logic [CNT_W-1:0]   arr_rd_lru,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic               rsp_victim_inv,
    output logic [1:0]         rsp_mesi,
    output logic [INDEX_W-1:0] rsp_index,
    output logic [TAG_W-1:0]   rsp_tag
);

    localparam logic [WAY_W:0]   ASSOC_CNT = (WAY_W+1)'(ASSOC);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(ASSOC - 1);
    localparam logic [1:0]       MESI_INV  = 2'b11;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t             state, state_nxt;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [WAY_W:0]     issue_cnt, issue_cnt_nxt;
    logic               cmp_valid;
    logic [WAY_W-1:0]   cmp_way;

    logic               have_inv, have_inv_nxt;
    logic [WAY_W-1:0]   inv_way, inv_way_nxt;
    logic               have_best, have_best_nxt;
    logic [WAY_W-1:0]   best_way, best_way_nxt;
    logic [CNT_W-1:0]   best_lru, best_lru_nxt;
    logic [1:0]         best_mesi, best_mesi_nxt;

    logic               hit_q, hit_nxt;
    logic [WAY_W-1:0]   way_q, way_nxt;
    logic               vinv_q, vinv_nxt;
    logic [1:0]         mesi_q, mesi_nxt;

    logic               accept;
    logic               issue;
    logic               state_valid;
    logic               tag_match;
    logic               unused_offset;

    assign accept        = (state == IDLE) && req_valid;
    assign issue         = (state == SCAN) && (issue_cnt < ASSOC_CNT);
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    // Unknown array contents fall through to "invalid, no match" so X never reaches rsp_hit.
    always_comb begin
        state_valid = 1'b0;
        tag_match   = 1'b0;
        if (arr_rd_mesi == 2'b00 || arr_rd_mesi == 2'b01 || arr_rd_mesi == 2'b10)
            state_valid = 1'b1;
        if (arr_rd_tag == tag_q)
            tag_match = 1'b1;
    end

    always_comb begin
        state_nxt     = state;
        issue_cnt_nxt = issue_cnt;
        have_inv_nxt  = have_inv;
        inv_way_nxt   = inv_way;
        have_best_nxt = have_best;
        best_way_nxt  = best_way;
        best_lru_nxt  = best_lru;
        best_mesi_nxt = best_mesi;
        hit_nxt       = hit_q;
        way_nxt       = way_q;
        vinv_nxt      = vinv_q;
        mesi_nxt      = mesi_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt     = SCAN;
                    issue_cnt_nxt = '0;
                    have_inv_nxt  = 1'b0;
                    have_best_nxt = 1'b0;
                end
            end
            SCAN: begin
                if (issue)
                    issue_cnt_nxt = issue_cnt + 1'b1;
                if (cmp_valid) begin
                    if (state_valid && tag_match) begin
                        state_nxt = RESP;
                        hit_nxt   = 1'b1;
                        way_nxt   = cmp_way;
                        vinv_nxt  = 1'b0;
                        mesi_nxt  = arr_rd_mesi;
                    end else begin
                        if (!state_valid && !have_inv) begin
                            have_inv_nxt = 1'b1;
                            inv_way_nxt  = cmp_way;
                        end
                        // Strict compare keeps the lowest way on equal LRU age.
                        if (state_valid && (!have_best || arr_rd_lru > best_lru)) begin
                            have_best_nxt = 1'b1;
                            best_way_nxt  = cmp_way;
                            best_lru_nxt  = arr_rd_lru;
                            best_mesi_nxt = arr_rd_mesi;
                        end
                        if (cmp_way == LAST_WAY) begin
                            state_nxt = RESP;
                            hit_nxt   = 1'b0;
                            if (have_inv_nxt) begin
                                way_nxt  = inv_way_nxt;
                                vinv_nxt = 1'b1;
                                mesi_nxt = MESI_INV;
                            end else begin
                                way_nxt  = best_way_nxt;
                                vinv_nxt = 1'b0;
                                mesi_nxt = best_mesi_nxt;
                            end
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tag_q     <= '0;
            index_q   <= '0;
            issue_cnt <= '0;
            cmp_valid <= 1'b0;
            cmp_way   <= '0;
            have_inv  <= 1'b0;
            inv_way   <= '0;
            have_best <= 1'b0;
            best_way  <= '0;
            best_lru  <= '0;
            best_mesi <= '0;
            hit_q     <= 1'b0;
            way_q     <= '0;
            vinv_q    <= 1'b0;
            mesi_q    <= '0;
        end else begin
            state     <= state_nxt;
            if (accept) begin
                tag_q   <= req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
                index_q <= req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
            end
            issue_cnt <= issue_cnt_nxt;
            cmp_valid <= issue;
            cmp_way   <= issue_cnt[WAY_W-1:0];
            have_inv  <= have_inv_nxt;
            inv_way   <= inv_way_nxt;
            have_best <= have_best_nxt;
            best_way  <= best_way_nxt;
            best_lru  <= best_lru_nxt;
            best_mesi <= best_mesi_nxt;
            hit_q     <= hit_nxt;
            way_q     <= way_nxt;
            vinv_q    <= vinv_nxt;
            mesi_q    <= mesi_nxt;
        end
    end

    // Outputs are forced low during reset even though state clears only at the next edge.
    assign req_ready      = !rst && (state == IDLE);
    assign arr_rd_en      = !rst && issue;
    assign arr_index      = rst ? '0 : index_q;
    assign arr_way        = rst ? '0 : issue_cnt[WAY_W-1:0];
    assign rsp_valid      = !rst && (state == RESP);
    assign rsp_hit        = !rst && hit_q;
    assign rsp_way        = rst ? '0 : way_q;
    assign rsp_victim_inv = !rst && vinv_q;
    assign rsp_mesi       = rst ? '0 : mesi_q;
    assign rsp_index      = rst ? '0 : index_q;
    assign rsp_tag        = rst ? '0 : tag_q;

endmodule

// File: tb/tb_l2_lookup_sequencer.sv
// Directed bench for l2_lookup_sequencer with a one-cycle-latency model of the
// tag/state array read port.
module tb_l2_lookup_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        arr_rd_en;
    logic [13:0] arr_index;
    logic [2:0]  arr_way;
    logic [11:0] arr_rd_tag  = '0;
    logic [1:0]  arr_rd_mesi = 2'b11;
    logic [2:0]  arr_rd_lru  = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [2:0]  rsp_way;
    logic        rsp_victim_inv;
    logic [1:0]  rsp_mesi;
    logic [13:0] rsp_index;
    logic [11:0] rsp_tag;

    logic [11:0] mem_tag  [8];
    logic [1:0]  mem_mesi [8];
    logic [2:0]  mem_lru  [8];

    int checks   = 0;
    int failures = 0;
    int cyc;

    l2_lookup_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .arr_rd_en      (arr_rd_en),
        .arr_index      (arr_index),
        .arr_way        (arr_way),
        .arr_rd_tag     (arr_rd_tag),
        .arr_rd_mesi    (arr_rd_mesi),
        .arr_rd_lru     (arr_rd_lru),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_hit        (rsp_hit),
        .rsp_way        (rsp_way),
        .rsp_victim_inv (rsp_victim_inv),
        .rsp_mesi       (rsp_mesi),
        .rsp_index      (rsp_index),
        .rsp_tag        (rsp_tag)
    );

    always #5 clk = ~clk;

    // Array read port: data for the strobed way appears the cycle after arr_rd_en.
    always @(posedge clk) begin
        if (arr_rd_en) begin
            arr_rd_tag  <= mem_tag[arr_way];
            arr_rd_mesi <= mem_mesi[arr_way];
            arr_rd_lru  <= mem_lru[arr_way];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillSet(input logic [11:0] tag, input logic [1:0] mesi);
        for (int w = 0; w < 8; w++) begin
            mem_tag[w]  = tag;
            mem_mesi[w] = mesi;
            mem_lru[w]  = 3'(w);
        end
    endtask

    // Called at a negedge: presents a request that is accepted at the next posedge (cycle 0).
    task automatic applyStimulus(input logic [31:0] addr);
        checkOutput("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_addr  = addr;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
    endtask

    // Returns the cycle number in which rsp_valid is first seen, bounded at 20.
    task automatic waitResponse(input logic [13:0] exp_index, output int n);
        n = 1;
        @(negedge clk);
        checkOutput("cycle1_arr_rd_en", 32'(arr_rd_en), 32'd1);
        checkOutput("cycle1_arr_way", 32'(arr_way), 32'd0);
        checkOutput("cycle1_arr_index", 32'(arr_index), 32'(exp_index));
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic finishResponse();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_handshake", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_after_handshake", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        fillSet(12'hAAA, 2'b01);

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_arr_rd_en", 32'(arr_rd_en), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

        // Test 1: reset held 3 cycles in the middle of a scan
        applyStimulus(32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("midscan_rst_arr_rd_en", 32'(arr_rd_en), 32'd0);
            checkOutput("midscan_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("midscan_rst_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midscan_release_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midscan_release_rsp_valid", 32'(rsp_valid), 32'd0);

        // Test 2: hit in way 2, state M
        fillSet(12'h0AA, 2'b01);
        mem_tag[2]  = 12'h123;
        mem_mesi[2] = 2'b00;
        applyStimulus(32'h1234_5678);
        waitResponse(14'h1159, cyc);
        checkOutput("t2_latency", 32'(cyc), 32'd5);
        checkOutput("t2_hit", 32'(rsp_hit), 32'd1);
        checkOutput("t2_way", 32'(rsp_way), 32'd2);
        checkOutput("t2_mesi", 32'(rsp_mesi), 32'd0);
        checkOutput("t2_index", 32'(rsp_index), 32'h1159);
        checkOutput("t2_tag", 32'(rsp_tag), 32'h123);
        finishResponse();

        // Test 3: all valid, no match; oldest LRU 7 at ways 1 and 3 -> way 1
        fillSet(12'h0AA, 2'b01);
        mem_mesi[1] = 2'b10;
        mem_lru[0] = 3'd1; mem_lru[1] = 3'd7; mem_lru[2] = 3'd3; mem_lru[3] = 3'd7;
        mem_lru[4] = 3'd0; mem_lru[5] = 3'd2; mem_lru[6] = 3'd5; mem_lru[7] = 3'd6;
        applyStimulus(32'h1234_5678);
        waitResponse(14'h1159, cyc);
        checkOutput("t3_latency", 32'(cyc), 32'd10);
        checkOutput("t3_hit", 32'(rsp_hit), 32'd0);
        checkOutput("t3_way", 32'(rsp_way), 32'd1);
        checkOutput("t3_victim_inv", 32'(rsp_victim_inv), 32'd0);
        checkOutput("t3_mesi", 32'(rsp_mesi), 32'd2);
        finishResponse();

        // Test 4: ways 4 and 6 invalid, way 6 holds the matching tag -> miss, victim way 4
        fillSet(12'h0AA, 2'b01);
        mem_mesi[4] = 2'b11;
        mem_mesi[6] = 2'b11;
        mem_tag[6]  = 12'h123;
        applyStimulus(32'h1234_5678);
        waitResponse(14'h1159, cyc);
        checkOutput("t4_latency", 32'(cyc), 32'd10);
        checkOutput("t4_hit", 32'(rsp_hit), 32'd0);
        checkOutput("t4_way", 32'(rsp_way), 32'd4);
        checkOutput("t4_victim_inv", 32'(rsp_victim_inv), 32'd1);
        checkOutput("t4_mesi", 32'(rsp_mesi), 32'd3);
        finishResponse();

        // Test 5: hit at way 0 held under back-pressure for 5 cycles
        fillSet(12'h0AA, 2'b01);
        mem_tag[0]  = 12'hFED;
        mem_mesi[0] = 2'b10;
        applyStimulus(32'hFED3_0040);
        waitResponse(14'h0C01, cyc);
        checkOutput("t5_latency", 32'(cyc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("t5_hold_hit", 32'(rsp_hit), 32'd1);
            checkOutput("t5_hold_way", 32'(rsp_way), 32'd0);
            checkOutput("t5_hold_mesi", 32'(rsp_mesi), 32'd2);
            checkOutput("t5_hold_tag", 32'(rsp_tag), 32'hFED);
            checkOutput("t5_hold_req_ready", 32'(req_ready), 32'd0);
        end
        fillSet(12'h0AA, 2'b01);
        mem_tag[1] = 12'h123; mem_mesi[1] = 2'b01;
        mem_tag[5] = 12'h123; mem_mesi[5] = 2'b01;
        finishResponse();

        // Test 6: accepted right after the handshake; matching tag in ways 1 and 5 -> way 1
        applyStimulus(32'h1234_5678);
        waitResponse(14'h1159, cyc);
        checkOutput("t6_latency", 32'(cyc), 32'd4);
        checkOutput("t6_hit", 32'(rsp_hit), 32'd1);
        checkOutput("t6_way", 32'(rsp_way), 32'd1);
        checkOutput("t6_mesi", 32'(rsp_mesi), 32'd1);
        finishResponse();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
